// File: rtl/riscv_wb_checker.sv
// riscv_wb_checker: write-back monitor for the single-cycle core.
// Compares retired register writes in order against a preloaded list.
module riscv_wb_checker #(
  parameter int XLEN      = 32,
  parameter int REG_W     = 5,
  parameter int DEPTH     = 16,
  parameter int TIMEOUT   = 1024,
  parameter int IGNORE_X0 = 1,
  localparam int AW       = $clog2(DEPTH),
  localparam int CW       = AW + 1
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             exp_we,
  input  logic [AW-1:0]    exp_addr,
  input  logic [REG_W-1:0] exp_rd,
  input  logic [XLEN-1:0]  exp_data,
  input  logic [CW-1:0]    num_exp,
  input  logic             start,
  input  logic             wb_en,
  input  logic [REG_W-1:0] wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [1:0]       fail_cause,
  output logic [AW-1:0]    err_index,
  output logic [XLEN-1:0]  err_data,
  output logic [CW-1:0]    match_count,
  output logic [15:0]      cycle_count
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PASS,
    FAIL
  } state_t;

  state_t state;

  logic [REG_W-1:0] mem_rd   [DEPTH];
  logic [XLEN-1:0]  mem_data [DEPTH];
  logic [CW-1:0]    num_lat;

  logic [AW-1:0] idx;
  logic [CW-1:0] num_clamp;
  logic [CW-1:0] mc_next;
  logic [15:0]   cc_next;
  logic          qual;
  logic          hit_timeout;
  logic          fail_now;
  logic          pass_now;
  logic [1:0]    fail_code;

  assign idx       = match_count[AW-1:0];
  assign num_clamp = (num_exp > CW'(DEPTH)) ? CW'(DEPTH) : num_exp;
  assign cc_next   = (cycle_count == 16'hFFFF) ? cycle_count
                                               : cycle_count + 16'd1;
  assign hit_timeout = 32'(cycle_count) >= 32'(TIMEOUT - 1);

  // Expected list survives reset so a run can be repeated without reload.
  always_ff @(posedge CLK) begin
    if (state == IDLE && exp_we) begin
      mem_rd[exp_addr]   <= exp_rd;
      mem_data[exp_addr] <= exp_data;
    end
  end

  always_comb begin
    qual      = wb_en && !(IGNORE_X0 != 0 && wb_rd == '0);
    fail_now  = 1'b0;
    pass_now  = 1'b0;
    fail_code = 2'b00;
    mc_next   = match_count;
    if (qual && wb_rd != mem_rd[idx]) begin
      fail_now  = 1'b1;
      fail_code = 2'b01;
    end else if (qual && wb_data != mem_data[idx]) begin
      fail_now  = 1'b1;
      fail_code = 2'b10;
    end else begin
      if (qual) mc_next = match_count + CW'(1);
      // A final match wins over a timeout in the same cycle.
      if (qual && mc_next == num_lat) begin
        pass_now = 1'b1;
      end else if (hit_timeout) begin
        fail_now  = 1'b1;
        fail_code = 2'b11;
      end
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail_cause  <= 2'b00;
      err_index   <= '0;
      err_data    <= '0;
      match_count <= '0;
      cycle_count <= '0;
      num_lat     <= '0;
    end else begin
      unique case (state)
        IDLE, PASS, FAIL: begin
          if (start) begin
            num_lat     <= num_clamp;
            match_count <= '0;
            cycle_count <= '0;
            fail_cause  <= 2'b00;
            err_index   <= '0;
            err_data    <= '0;
            if (num_clamp == '0) begin
              state <= PASS;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
              done  <= 1'b0;
              pass  <= 1'b0;
            end
          end
        end
        RUN: begin
          cycle_count <= cc_next;
          match_count <= mc_next;
          if (fail_now) begin
            state      <= FAIL;
            busy       <= 1'b0;
            done       <= 1'b1;
            pass       <= 1'b0;
            fail_cause <= fail_code;
            err_index  <= mc_next[AW-1:0];
            err_data   <= (fail_code == 2'b11) ? '0 : wb_data;
          end else if (pass_now) begin
            state <= PASS;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_wb_checker.sv
// Bench for riscv_wb_checker: two instances (x0 ignored / checked)
// driven in parallel, checked against a cycle model plus literals.
module tb_riscv_wb_checker;

  logic        CLK = 1'b0;
  logic        rst_n = 1'b0;
  logic        exp_we = 1'b0;
  logic [3:0]  exp_addr = '0;
  logic [4:0]  exp_rd = '0;
  logic [31:0] exp_data = '0;
  logic [4:0]  num_exp = '0;
  logic        start = 1'b0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;

  logic [1:0]  busy, done, pass;
  logic [1:0]  fail_cause  [2];
  logic [3:0]  err_index   [2];
  logic [31:0] err_data    [2];
  logic [4:0]  match_count [2];
  logic [15:0] cycle_count [2];

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  riscv_wb_checker #(.TIMEOUT(8), .IGNORE_X0(1)) u0 (
    .CLK(CLK), .rst_n(rst_n),
    .exp_we(exp_we), .exp_addr(exp_addr),
    .exp_rd(exp_rd), .exp_data(exp_data),
    .num_exp(num_exp), .start(start),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .fail_cause(fail_cause[0]), .err_index(err_index[0]),
    .err_data(err_data[0]), .match_count(match_count[0]),
    .cycle_count(cycle_count[0])
  );

  riscv_wb_checker #(.TIMEOUT(16), .IGNORE_X0(0)) u1 (
    .CLK(CLK), .rst_n(rst_n),
    .exp_we(exp_we), .exp_addr(exp_addr),
    .exp_rd(exp_rd), .exp_data(exp_data),
    .num_exp(num_exp), .start(start),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .fail_cause(fail_cause[1]), .err_index(err_index[1]),
    .err_data(err_data[1]), .match_count(match_count[1]),
    .cycle_count(cycle_count[1])
  );

  // Model: 0 idle, 1 run, 2 pass, 3 fail
  int          st [2] = '{0, 0};
  int          mc [2] = '{0, 0};
  int          cc [2] = '{0, 0};
  int          cs [2] = '{0, 0};
  int          ei [2] = '{0, 0};
  int          nl [2] = '{0, 0};
  logic [31:0] ed [2] = '{0, 0};
  int          mrd [2][16];
  logic [31:0] mdt [2][16];
  int          ign [2] = '{1, 0};
  int          tmo [2] = '{8, 16};

  task automatic lit(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_step(input int m);
    int  old_cc;
    int  n;
    bit  q;
    if (st[m] == 1) begin
      old_cc = cc[m];
      if (cc[m] < 65535) cc[m]++;
      q = wb_en && !(ign[m] == 1 && wb_rd == 0);
      if (q && int'(wb_rd) != mrd[m][mc[m]]) begin
        st[m] = 3; cs[m] = 1; ei[m] = mc[m]; ed[m] = wb_data;
      end else if (q && wb_data != mdt[m][mc[m]]) begin
        st[m] = 3; cs[m] = 2; ei[m] = mc[m]; ed[m] = wb_data;
      end else begin
        if (q) begin
          mc[m]++;
          if (mc[m] == nl[m]) st[m] = 2;
        end
        if (st[m] == 1 && old_cc == tmo[m] - 1) begin
          st[m] = 3; cs[m] = 3; ei[m] = mc[m]; ed[m] = 0;
        end
      end
    end else begin
      if (st[m] == 0 && exp_we) begin
        mrd[m][exp_addr] = int'(exp_rd);
        mdt[m][exp_addr] = exp_data;
      end
      if (start) begin
        n = (num_exp > 16) ? 16 : int'(num_exp);
        nl[m] = n; mc[m] = 0; cc[m] = 0;
        cs[m] = 0; ei[m] = 0; ed[m] = 0;
        st[m] = (n == 0) ? 2 : 1;
      end
    end
  endtask

  always @(posedge CLK)
    if (rst_n)
      for (int m = 0; m < 2; m++) model_step(m);

  always @(negedge rst_n)
    for (int m = 0; m < 2; m++) begin
      st[m] = 0; mc[m] = 0; cc[m] = 0;
      cs[m] = 0; ei[m] = 0; ed[m] = 0; nl[m] = 0;
    end

  always @(negedge CLK)
    for (int m = 0; m < 2; m++) begin
      lit($sformatf("busy%0d", m), 32'(busy[m]), 32'(st[m] == 1));
      lit($sformatf("done%0d", m), 32'(done[m]), 32'(st[m] >= 2));
      lit($sformatf("pass%0d", m), 32'(pass[m]), 32'(st[m] == 2));
      lit($sformatf("cause%0d", m), 32'(fail_cause[m]), 32'(cs[m]));
      lit($sformatf("eidx%0d", m), 32'(err_index[m]), 32'(ei[m]));
      lit($sformatf("edata%0d", m), err_data[m], ed[m]);
      lit($sformatf("mc%0d", m), 32'(match_count[m]), 32'(mc[m]));
      lit($sformatf("cc%0d", m), 32'(cycle_count[m]), 32'(cc[m]));
    end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic wr(input int a, input int rd, input logic [31:0] d);
    exp_we = 1'b1; exp_addr = 4'(a); exp_rd = 5'(rd); exp_data = d;
    tick();
    exp_we = 1'b0;
  endtask

  task automatic go(input int n);
    num_exp = 5'(n); start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wb(input int rd, input logic [31:0] d);
    wb_en = 1'b1; wb_rd = 5'(rd); wb_data = d;
    tick();
    wb_en = 1'b0;
  endtask

  task automatic load4();
    wr(0, 3, 32'hFFFF_FFFF);
    wr(1, 4, 32'h1);
    wr(2, 5, 32'hC);
    wr(3, 6, 32'h5);
  endtask

  task automatic zeros(input string tag);
    for (int m = 0; m < 2; m++) begin
      lit($sformatf("%s busy%0d", tag, m), 32'(busy[m]), 0);
      lit($sformatf("%s done%0d", tag, m), 32'(done[m]), 0);
      lit($sformatf("%s pass%0d", tag, m), 32'(pass[m]), 0);
      lit($sformatf("%s mc%0d", tag, m), 32'(match_count[m]), 0);
      lit($sformatf("%s cc%0d", tag, m), 32'(cycle_count[m]), 0);
    end
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1 zeros("rst");
    #4 rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    zeros("por");
    rst_n = 1'b1;
    tick();

    // Four in-order matches with gaps
    load4();
    go(4);
    idle(1);
    wb(3, 32'hFFFF_FFFF);
    wb(4, 32'h1);
    idle(1);
    wb(5, 32'hC);
    wb(6, 32'h5);
    lit("s1 pass", 32'(pass[0]), 1);
    lit("s1 mc", 32'(match_count[0]), 4);
    lit("s1 cc", 32'(cycle_count[0]), 6);
    idle(2);

    // Restart from PASS, data mismatch on the second entry
    go(4);
    wb(3, 32'hFFFF_FFFF);
    wb(4, 32'h0);
    lit("s2 cause", 32'(fail_cause[0]), 2);
    lit("s2 eidx", 32'(err_index[0]), 1);
    lit("s2 edata", err_data[0], 0);
    lit("s2 mc", 32'(match_count[0]), 1);

    // Load during FAIL is ignored; start during RUN is ignored
    wr(0, 9, 32'h99);
    go(4);
    wb(3, 32'hFFFF_FFFF);
    go(4);
    wb(7, 32'h12);
    lit("s3 cause", 32'(fail_cause[1]), 1);
    lit("s3 eidx", 32'(err_index[1]), 1);
    lit("s3 edata", err_data[1], 32'h12);
    go(4);
    wb(7, 32'hAB);
    lit("s3b cause", 32'(fail_cause[0]), 1);
    lit("s3b eidx", 32'(err_index[0]), 0);

    // x0 write-back: ignored by u0, rd mismatch for u1
    do_reset();
    load4();
    go(4);
    wb(3, 32'hFFFF_FFFF);
    wb(0, 32'h55);
    wb(4, 32'h1);
    wb(5, 32'hC);
    wb(6, 32'h5);
    lit("s4 pass0", 32'(pass[0]), 1);
    lit("s4 cause1", 32'(fail_cause[1]), 1);
    lit("s4 eidx1", 32'(err_index[1]), 1);

    // Timeout with one of two write-backs
    do_reset();
    go(2);
    wb(3, 32'hFFFF_FFFF);
    idle(7);
    lit("s5 cause0", 32'(fail_cause[0]), 3);
    lit("s5 eidx0", 32'(err_index[0]), 1);
    lit("s5 cc0", 32'(cycle_count[0]), 8);
    lit("s5 busy1", 32'(busy[1]), 1);
    idle(8);
    lit("s5 cause1", 32'(fail_cause[1]), 3);
    lit("s5 cc1", 32'(cycle_count[1]), 16);

    // Final match exactly on the timeout cycle
    do_reset();
    go(2);
    wb(3, 32'hFFFF_FFFF);
    idle(6);
    wb(4, 32'h1);
    lit("s6 pass0", 32'(pass[0]), 1);
    lit("s6 cc0", 32'(cycle_count[0]), 8);

    // Mismatch on the timeout cycle keeps the mismatch cause
    go(2);
    wb(3, 32'hFFFF_FFFF);
    idle(6);
    wb(4, 32'h7);
    lit("s7 cause0", 32'(fail_cause[0]), 2);
    lit("s7 edata0", err_data[0], 32'h7);

    // Reset mid-RUN, then rerun from retained memory
    go(4);
    wb(3, 32'hFFFF_FFFF);
    do_reset();
    go(4);
    wb(3, 32'hFFFF_FFFF);
    wb(4, 32'h1);
    wb(5, 32'hC);
    wb(6, 32'h5);
    lit("s8 pass0", 32'(pass[0]), 1);
    lit("s8 pass1", 32'(pass[1]), 1);

    // Empty list passes on the start edge
    go(0);
    lit("s9 pass0", 32'(pass[0]), 1);
    lit("s9 mc0", 32'(match_count[0]), 0);

    // Full list, num_exp clamped to 16
    do_reset();
    for (int i = 0; i < 16; i++)
      wr(i, i + 1, 32'hA5A5_A5A5 ^ (32'(i) * 32'h0101_0101));
    go(31);
    for (int i = 0; i < 16; i++)
      wb(i + 1, 32'hA5A5_A5A5 ^ (32'(i) * 32'h0101_0101));
    lit("s10 pass1", 32'(pass[1]), 1);
    lit("s10 mc1", 32'(match_count[1]), 16);
    lit("s10 cc1", 32'(cycle_count[1]), 16);
    lit("s10 cause0", 32'(fail_cause[0]), 3);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
